// File: rtl/axi_stream_insert_header.sv
// axi_stream_insert_header: prepends a 0..DATA_BYTE_WD byte header to an AXI-Stream packet
// and repacks the merged byte stream into full beats.
module axi_stream_insert_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
    output logic                    ready_insert
);
    localparam int CW = BYTE_CNT_WD + 1;
    localparam logic [CW-1:0] FULL = CW'(DATA_BYTE_WD);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t               state;
    logic                 live, eop;
    logic [DATA_WD-1:0]   res, din_m, hdr_m, hdr_la;
    logic [CW-1:0]        res_cnt, n_in, n_hdr, tot;
    logic [2*DATA_WD-1:0] cat;
    logic                 out_free, take_in, take_hdr, out_done;
    logic                 unused;

    assign unused = ^byte_insert_cnt;

    always_comb begin
        din_m = '0;
        hdr_m = '0;
        n_in  = '0;
        n_hdr = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            din_m[8*i +: 8] = keep_in[i] ? data_in[8*i +: 8] : 8'h00;
            hdr_m[8*i +: 8] = keep_insert[i] ? data_insert[8*i +: 8] : 8'h00;
            n_in  = n_in + CW'(keep_in[i]);
            n_hdr = n_hdr + CW'(keep_insert[i]);
        end
        tot    = res_cnt + n_in;
        // residual bytes sit left-aligned; the new beat lands right behind them
        cat    = {res, {DATA_WD{1'b0}}} | ({din_m, {DATA_WD{1'b0}}} >> (8 * res_cnt));
        hdr_la = hdr_m << (8 * (DATA_BYTE_WD - int'(n_hdr)));
    end

    assign out_free     = !valid_out || ready_out;
    assign ready_in     = state == STREAM && !eop && out_free;
    assign ready_insert = live && state == IDLE;
    assign take_in      = valid_in && ready_in;
    assign take_hdr     = valid_insert && ready_insert;
    assign out_done     = valid_out && ready_out && last_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            live      <= 1'b0;
            eop       <= 1'b0;
            res       <= '0;
            res_cnt   <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
        end else begin
            live <= 1'b1;
            if (valid_out && ready_out)
                valid_out <= 1'b0;
            case (state)
                IDLE: if (take_hdr) begin
                    state <= STREAM;
                    eop   <= 1'b0;
                    // a full-width header is a complete beat on its own
                    if (n_hdr == FULL) begin
                        valid_out <= 1'b1;
                        data_out  <= hdr_m;
                        keep_out  <= '1;
                        last_out  <= 1'b0;
                        res       <= '0;
                        res_cnt   <= '0;
                    end else begin
                        res     <= hdr_la;
                        res_cnt <= n_hdr;
                    end
                end
                STREAM: begin
                    if (take_in && (tot >= FULL || last_in)) begin
                        valid_out <= 1'b1;
                        data_out  <= cat[2*DATA_WD-1:DATA_WD];
                        keep_out  <= tot >= FULL ? '1 : ~({DATA_BYTE_WD{1'b1}} >> tot);
                        last_out  <= last_in && tot <= FULL;
                        res       <= tot >= FULL ? cat[DATA_WD-1:0] : '0;
                        res_cnt   <= tot >= FULL ? tot - FULL : '0;
                        if (last_in) begin
                            eop <= 1'b1;
                            if (tot > FULL)
                                state <= FLUSH;
                        end
                    end else if (take_in) begin
                        res     <= cat[2*DATA_WD-1:DATA_WD];
                        res_cnt <= tot;
                    end
                    if (out_done)
                        state <= IDLE;
                end
                FLUSH: begin
                    if (res_cnt != '0 && out_free) begin
                        valid_out <= 1'b1;
                        data_out  <= res;
                        keep_out  <= ~({DATA_BYTE_WD{1'b1}} >> res_cnt);
                        last_out  <= 1'b1;
                        res       <= '0;
                        res_cnt   <= '0;
                    end
                    if (out_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_stream_insert_header.sv
// tb_axi_stream_insert_header: directed and randomized packets against a byte-queue
// scoreboard, plus reset, backpressure stability and back-to-back header checks.
module tb_axi_stream_insert_header;
    logic        clk = 0, rst_n = 0;
    logic        valid_in = 0, last_in = 0, ready_in;
    logic [31:0] data_in = 0;
    logic [3:0]  keep_in = 0;
    logic        valid_out, last_out, ready_out = 1;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        valid_insert = 0, ready_insert;
    logic [31:0] data_insert = 0;
    logic [3:0]  keep_insert = 0;
    logic [1:0]  byte_insert_cnt = 0;

    int total = 0, bad = 0, cyc = 0, last_cyc = 0, hdr_cyc = 0;
    bit bp = 0, mon_en = 1, stall = 0;
    logic [63:0] held;
    logic [31:0] eq_d[$];
    logic [3:0]  eq_k[$];
    logic        eq_l[$];
    logic [31:0] pay_d[64];
    logic [3:0]  hks[5] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hf};
    logic [3:0]  lks[4] = '{4'h8, 4'hc, 4'he, 4'hf};

    axi_stream_insert_header dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
        .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
        .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end
    initial forever begin
        @(posedge clk);
        #1;
        ready_out = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        eq_d.push_back(d);
        eq_k.push_back(k);
        eq_l.push_back(l);
    endtask

    // reference: flatten header then payload into bytes, cut into 4-byte beats
    task automatic model_pkt(input logic [31:0] hd, input logic [3:0] hk, input int n, input logic [3:0] lk);
        logic [7:0]  q[$];
        logic [31:0] d;
        logic [3:0]  k;
        for (int i = 3; i >= 0; i--) if (hk[i]) q.push_back(hd[8*i +: 8]);
        for (int b = 0; b < n; b++)
            for (int i = 3; i >= 0; i--) if (b < n - 1 || lk[i]) q.push_back(pay_d[b][8*i +: 8]);
        while (q.size() > 0) begin
            d = 0;
            k = 0;
            for (int i = 3; i >= 0 && q.size() > 0; i--) begin
                d[8*i +: 8] = q.pop_front();
                k[i] = 1'b1;
            end
            expect_beat(d, k, q.size() == 0);
        end
    endtask

    initial forever begin
        logic [31:0] ed, m;
        logic [3:0]  ek;
        logic        el;
        @(negedge clk);
        if (stall) chk("stable", {26'd0, valid_out, last_out, keep_out, data_out}, held);
        stall = rst_n && valid_out && !ready_out;
        held  = {26'd0, valid_out, last_out, keep_out, data_out};
        if (mon_en && rst_n && valid_out && ready_out) begin
            if (eq_d.size() == 0) chk("extra_beat", 1, 0);
            else begin
                ed = eq_d.pop_front();
                ek = eq_k.pop_front();
                el = eq_l.pop_front();
                for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{ek[i]}};
                chk("data", data_out & m, ed & m);
                chk("keep", keep_out, ek);
                chk("last", last_out, el);
            end
            if (last_out) last_cyc = cyc + 1;
        end
    end

    task automatic send_hdr(input logic [31:0] d, input logic [3:0] k);
        bit acc = 0;
        valid_insert = 1;
        data_insert  = d;
        keep_insert  = k;
        for (int t = 0; t < 1000 && !acc; t++) begin
            @(negedge clk);
            acc = ready_insert;
            if (acc) hdr_cyc = cyc + 1;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("hdr_timeout", 0, 1);
        valid_insert = 0;
    endtask

    task automatic send_payload(input int n, input logic [3:0] lk, input int gmax);
        for (int b = 0; b < n; b++) begin
            bit acc = 0;
            repeat (gmax > 0 ? $urandom_range(0, gmax) : 0) begin @(posedge clk); #1; end
            valid_in = 1;
            data_in  = pay_d[b];
            keep_in  = b == n - 1 ? lk : 4'hf;
            last_in  = b == n - 1;
            for (int t = 0; t < 1000 && !acc; t++) begin
                @(negedge clk);
                acc = ready_in;
                @(posedge clk);
                #1;
            end
            if (!acc) chk("payload_timeout", 0, 1);
            valid_in = 0;
            last_in  = 0;
        end
    endtask

    task automatic drain;
        for (int t = 0; t < 1000 && eq_d.size() > 0; t++) @(posedge clk);
        chk("drain_left", eq_d.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_keep_out", keep_out, 0);
        chk("rst_last_out", last_out, 0);
        chk("rst_ready_in", ready_in, 0);
        chk("rst_ready_insert", ready_insert, 0);
        @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_insert_after_rst", ready_insert, 1);
        @(posedge clk);
        #1;

        // full-width header goes out alone, payload unshifted
        pay_d[0] = 32'h11223344; pay_d[1] = 32'h55667788;
        expect_beat(32'hA0A1A2A3, 4'hf, 0);
        expect_beat(32'h11223344, 4'hf, 0);
        expect_beat(32'h55667788, 4'hf, 1);
        send_hdr(32'hA0A1A2A3, 4'hf);
        send_payload(2, 4'hf, 0);
        drain();

        // two header bytes force a flush beat
        expect_beat(32'hA0A11122, 4'hf, 0);
        expect_beat(32'h33445566, 4'hf, 0);
        expect_beat(32'h77880000, 4'hc, 1);
        send_hdr(32'h0000A0A1, 4'h3);
        send_payload(2, 4'hf, 0);
        drain();

        // one header byte plus three payload bytes fill exactly one beat
        pay_d[0] = 32'h11223344;
        expect_beat(32'hB0112233, 4'hf, 1);
        send_hdr(32'h000000B0, 4'h1);
        send_payload(1, 4'he, 0);
        drain();

        // empty header: payload passes through with its partial last beat
        pay_d[0] = 32'h01020304; pay_d[1] = 32'h05060708;
        expect_beat(32'h01020304, 4'hf, 0);
        expect_beat(32'h05060000, 4'hc, 1);
        send_hdr(32'hFFFFFFFF, 4'h0);
        send_payload(2, 4'hc, 0);
        drain();

        // reset in the middle of a packet, nothing buffered may leak out
        mon_en = 0;
        pay_d[0] = 32'hDEADBEEF; pay_d[1] = 32'hCAFEF00D;
        send_hdr(32'h0000C0C1, 4'h3);
        send_payload(1, 4'hf, 0);
        rst_n = 0;
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("midrst_valid_out", valid_out, 0);
        chk("midrst_data_out", data_out, 0);
        chk("midrst_keep_out", keep_out, 0);
        chk("midrst_last_out", last_out, 0);
        chk("midrst_ready_in", ready_in, 0);
        chk("midrst_ready_insert", ready_insert, 0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ready_insert_rel", ready_insert, 1);
        mon_en = 1;
        @(posedge clk);
        #1;
        pay_d[0] = 32'h11223344; pay_d[1] = 32'h55667788;
        expect_beat(32'hA0A11122, 4'hf, 0);
        expect_beat(32'h33445566, 4'hf, 0);
        expect_beat(32'h77880000, 4'hc, 1);
        send_hdr(32'h0000A0A1, 4'h3);
        send_payload(2, 4'hf, 0);
        drain();

        // second header is held until the first packet's last beat has left
        pay_d[0] = 32'h10111213; pay_d[1] = 32'h14151617; pay_d[2] = 32'h18191A1B;
        model_pkt(32'h00D0D1D2, 4'h7, 3, 4'hf);
        send_hdr(32'h00D0D1D2, 4'h7);
        fork
            send_payload(3, 4'hf, 0);
            send_hdr(32'h0000E0E1, 4'h3);
        join
        drain();
        chk("hdr2_after_last", hdr_cyc > last_cyc, 1);
        pay_d[0] = 32'h20212223; pay_d[1] = 32'h24250000;
        model_pkt(32'h0000E0E1, 4'h3, 2, 4'hc);
        send_payload(2, 4'hc, 0);
        drain();

        // randomized headers, last keeps, input gaps and output stalls
        bp = 1;
        for (int p = 0; p < 4; p++) begin
            logic [31:0] hd;
            logic [3:0]  hk, lk;
            hd = $urandom;
            hk = hks[$urandom_range(0, 4)];
            lk = lks[$urandom_range(0, 3)];
            for (int b = 0; b < 13; b++) pay_d[b] = $urandom;
            model_pkt(hd, hk, 13, lk);
            send_hdr(hd, hk);
            send_payload(13, lk, 2);
            drain();
        end
        bp = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_stream_insert_header.md
AXI_STREAM_INSERT_HEADER -- requirements
Module: axi_stream_insert_header

Interface
REQ-001 DATA_WD, 32, beat width in bits (multiple of 8).
REQ-002 DATA_BYTE_WD, DATA_WD/8, bytes per beat.
REQ-003 BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of byte_insert_cnt.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 valid_in / data_in / keep_in / last_in  in  1/DATA_WD/DATA_BYTE_WD/1  payload stream.
REQ-007 ready_in  out  1  payload accepted when valid_in&&ready_in.
REQ-008 valid_out / data_out / keep_out / last_out  out  1/DATA_WD/DATA_BYTE_WD/1  merged stream.
REQ-009 ready_out  in  1  downstream ready.
REQ-010 valid_insert / data_insert / keep_insert  in  1/DATA_WD/DATA_BYTE_WD  header beat.
REQ-011 byte_insert_cnt  in  BYTE_CNT_WD  informational header byte count; ignored (keep_insert is authoritative); may be left unconnected.
REQ-012 ready_insert  out  1  header accepted when valid_insert&&ready_insert.

Function
REQ-013 Byte order: byte 0 of a beat = bits [DATA_WD-1:DATA_WD-8] (MSB first); keep bit i qualifies byte lane i (bit 3 = MSB lane).
REQ-014 keep_insert is right-aligned contiguous (0000,0001,0011,0111,1111); H = popcount; the H LSB lanes of data_insert are the header, in MSB-to-LSB order.
REQ-015 keep_in = all ones except on the last_in beat, where it is left-aligned contiguous (1000..1111).
REQ-016 Output packet = H header bytes followed by all valid payload bytes, repacked into full beats; every non-last beat keep_out=1111; last beat keep_out left-aligned with ((H+N-1) mod 4)+1 ones (N = payload bytes); last_out only on that beat.
REQ-017 States: IDLE (ready_insert=1, ready_in=0), STREAM (ready_insert=0, accept payload), FLUSH (emit residual beat after last_in, ready_in=0).
REQ-018 IDLE->STREAM on header handshake; payload of a packet is accepted only after its header; no same-cycle header+payload acceptance.
REQ-019 STREAM->FLUSH when last_in accepted and residual bytes remain that do not fit in the beat being emitted; else STREAM->IDLE on last_out handshake.
REQ-020 FLUSH->IDLE on last_out handshake; ready_insert returns high the cycle after.
REQ-021 H=0 (keep_insert=0000): payload passes unchanged.
REQ-022 H=4: header beat emitted alone first, then payload beats unshifted.
REQ-023 Outputs registered; each output beat valid the cycle after its last contributing byte is accepted.
REQ-024 AXI rules: once valid_out=1, data_out/keep_out/last_out stay stable until ready_out=1; valid_out never depends on ready_out.
REQ-025 Throughput: one beat per cycle when valid_in and ready_out continuously high; only bubble is the FLUSH beat.
REQ-026 Backpressure: ready_in=0 whenever the output register is full and ready_out=0; no byte lost or duplicated.
REQ-027 valid_insert held during a packet waits (ready_insert=0) until IDLE.

Reset
REQ-028 While rst_n=0 at a clock edge: valid_out=0, data_out=0, keep_out=0, last_out=0, ready_in=0, ready_insert=0, state=IDLE, residual cleared.
REQ-029 First edge with rst_n=1: ready_insert=1.
REQ-030 Reset mid-packet discards all buffered bytes; no partial beat emitted afterwards.

Verification
REQ-031 keep_insert=1111, data_insert=A0A1A2A3, payload 11223344, 55667788(last, 1111) -> A0A1A2A3, 11223344, 55667788 last keep 1111.
REQ-032 keep_insert=0011, data_insert=0000A0A1, payload 11223344, 55667788(last, 1111) -> A0A11122, 33445566, 7788xxxx last keep 1100.
REQ-033 keep_insert=0001, data_insert=000000B0, single payload 11223344 keep 1110 last -> one beat B0112233 keep 1111 last.
REQ-034 Random ready_out/valid_in gaps, 13-beat packets, random keep_insert -> output matches byte-queue model; beat fields stable while valid_out&&!ready_out.
REQ-035 rst_n low mid-packet for 1 cycle -> all outputs 0 next edge, ready_insert=1 after release, next packet correct.
REQ-036 Back-to-back packets with valid_insert held high -> second header accepted only after first last_out handshake.
